// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution window generator
// and the multiplier array it feeds.
package conv_pkg;

  localparam int CONV_BITS  = 17;
  localparam int CONV_K     = 3;
  localparam int CONV_IMG_W = 28;
  localparam int CONV_IMG_H = 28;

  typedef logic signed [CONV_BITS-1:0] pixel_t;
  typedef pixel_t [CONV_K*CONV_K-1:0] window_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image-row delay line: the output is the pixel pushed DEPTH shifts ago,
// i.e. the same column of the previous row when DEPTH equals the image width.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int BITS  = CONV_BITS,
  parameter int DEPTH = CONV_IMG_W
) (
  input  logic            clk,
  input  logic            shift_en_i,
  input  logic [BITS-1:0] din_i,
  output logic [BITS-1:0] dout_o
);

  logic [DEPTH-1:0][BITS-1:0] mem_q;

  // Row storage shifts only on accepted pixels; contents need no reset.
  always_ff @(posedge clk) begin
    if (shift_en_i) begin
      mem_q <= {mem_q[DEPTH-2:0], din_i};
    end
  end

  assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// KxK sliding-window generator over a raster pixel stream, no padding.
// Define CONV_WIN_STRIDE2_EN to emit only windows at even offsets (stride 2).
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int BITS  = CONV_BITS,
  parameter int K     = CONV_K,
  parameter int IMG_W = CONV_IMG_W,
  parameter int IMG_H = CONV_IMG_H
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [BITS-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [K*K*BITS-1:0]   out_window,
  output logic                  out_last
);

  localparam int CW = cnt_width(IMG_W);
  localparam int RW = cnt_width(IMG_H);
  localparam int WW = K * K * BITS;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
`ifdef CONV_WIN_STRIDE2_EN
  localparam logic [CW-1:0] COL_EMIT_LAST = CW'(K - 1 + 2 * ((IMG_W - K) / 2));
  localparam logic [RW-1:0] ROW_EMIT_LAST = RW'(K - 1 + 2 * ((IMG_H - K) / 2));
`endif

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [WW-1:0]   win_q, win_d;
  logic            accept_s, emit_s, last_s;
  logic [BITS-1:0] lb_chain [K];

  assign in_ready = !out_valid_q || out_ready;
  assign accept_s = in_valid && in_ready;

  // lb_chain[n] is the current pixel delayed by n rows, same column.
  assign lb_chain[0] = in_data;
  for (genvar g = 0; g < K - 1; g++) begin : g_lb
    conv_line_buffer #(
      .BITS  (BITS),
      .DEPTH (IMG_W)
    ) u_lb (
      .clk        (clk),
      .shift_en_i (accept_s),
      .din_i      (lb_chain[g]),
      .dout_o     (lb_chain[g+1])
    );
  end

  // Does the pixel at (row_q, col_q) complete an emitted window, and is it the frame's final one.
  always_comb begin
    emit_s = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
    last_s = (row_q == ROW_LAST) && (col_q == COL_LAST);
`ifdef CONV_WIN_STRIDE2_EN
    emit_s = emit_s && (row_q[0] == ROW_FIRST[0]) && (col_q[0] == COL_FIRST[0]);
    last_s = (row_q == ROW_EMIT_LAST) && (col_q == COL_EMIT_LAST);
`endif
  end

  // Raster position counters, wrapping at row and frame end.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept_s) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_q + RW'(1'b1);
        end
      end else begin
        col_d = col_q + CW'(1'b1);
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Window shift and output handshake; everything holds while stalled.
  always_comb begin
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (accept_s) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          win_d[(i*K+j)*BITS +: BITS] = win_q[(i*K+j+1)*BITS +: BITS];
        end
        win_d[(i*K+K-1)*BITS +: BITS] = lb_chain[K-1-i];
      end
      out_valid_d = emit_s;
      out_last_d  = emit_s && last_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      win_q       <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      win_q       <= win_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_window = win_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: windows are derived from a stored
// image of each frame and compared with what the block hands downstream.
module tb_conv_window_gen;

  localparam int BITS = 17;
  localparam int K    = 3;
`ifdef CONV_WIN_STRIDE2_EN
  localparam int IMG_W = 5;
  localparam int IMG_H = 5;
`else
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
`endif
  localparam int NPIX      = IMG_W * IMG_H;
  localparam int WW        = K * K * BITS;
  localparam int NWIN      = 4;
  localparam int FIRST_IDX = (K - 1) * IMG_W + (K - 1);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic signed [BITS-1:0] in_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [WW-1:0]          out_window;
  logic                   out_last;

  conv_window_gen #(
    .BITS  (BITS),
    .K     (K),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_window (out_window),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] win;
    logic          last;
    int            idx;
    int            cyc;
  } rec_t;

  rec_t          exp_q[$];
  rec_t          got_q[$];
  rec_t          cap_r;
  int            acc_cyc[$];
  int            cyc = 0;
  logic [BITS-1:0] frame_pix [NPIX];
  int            checks = 0;
  int            failures = 0;
  bit            drv_timeout = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record accepted pixels and consumed windows, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
        cap_r.win  = out_window;
        cap_r.last = out_last;
        cap_r.idx  = 0;
        cap_r.cyc  = cyc;
        got_q.push_back(cap_r);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    exp_q.delete();
    got_q.delete();
    acc_cyc.delete();
    drv_timeout = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic fill_seq(input int base);
    for (int k = 0; k < NPIX; k++) frame_pix[k] = BITS'(base + k);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < NPIX; k++) frame_pix[k] = BITS'($urandom);
  endtask

  // Offer one pixel until accepted; optional input bubbles and random out_ready.
  task automatic send_pixel(input logic [BITS-1:0] v, input bit rv, input bit rr);
    bit got = 1'b0;
    if (rv) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        if (rr) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = v;
    for (int n = 0; n < 200 && !got; n++) begin
      if (rr) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) drv_timeout = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit rv, input bit rr);
    for (int k = 0; k < n; k++) send_pixel(frame_pix[k], rv, rr);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected windows of the stored frame in raster order of bottom-right pixel.
  task automatic model_frame(input int idx_base);
    rec_t e;
    int   n0 = exp_q.size();
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (r < K - 1 || c < K - 1) continue;
`ifdef CONV_WIN_STRIDE2_EN
        if (((r - K + 1) % 2) != 0 || ((c - K + 1) % 2) != 0) continue;
`endif
        e.win = '0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            e.win[(i*K+j)*BITS +: BITS] = frame_pix[(r-K+1+i)*IMG_W + (c-K+1+j)];
        e.last = 1'b0;
        e.idx  = idx_base + r * IMG_W + c;
        e.cyc  = 0;
        exp_q.push_back(e);
      end
    end
    if (exp_q.size() > n0) begin
      e = exp_q.pop_back();
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    do_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    checks++;
    if (out_window !== '0) begin failures++; $display("FAIL reset_out_window got=%h want=0", out_window); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  task automatic test_stream();
    logic [WW-1:0] w;
    do_reset();
    out_ready = 1'b1;
    fill_seq(0);
    model_frame(0);
    send_frame(NPIX, 1'b0, 1'b0);
    drain();
    checks++;
    if (drv_timeout !== 1'b0) begin failures++; $display("FAIL stream_timeout got=1 want=0"); end
    checks++;
    if (got_q.size() !== NWIN) begin failures++; $display("FAIL stream_count got=%0d want=%0d", got_q.size(), NWIN); end
    for (int n = 0; n < exp_q.size() && n < got_q.size(); n++) begin
      checks++;
      if (got_q[n].win !== exp_q[n].win) begin failures++; $display("FAIL stream_win[%0d] got=%h want=%h", n, got_q[n].win, exp_q[n].win); end
      checks++;
      if (got_q[n].last !== exp_q[n].last) begin failures++; $display("FAIL stream_last[%0d] got=%b want=%b", n, got_q[n].last, exp_q[n].last); end
      checks++;
      if (exp_q[n].idx >= acc_cyc.size() || got_q[n].cyc !== acc_cyc[exp_q[n].idx] + 1) begin
        failures++; $display("FAIL stream_latency[%0d] got_cycle=%0d want_one_after_accept_of_pixel=%0d", n, got_q[n].cyc, exp_q[n].idx);
      end
    end
    checks++;
    if (got_q.size() == 0) begin
      failures++; $display("FAIL stream_corners got=no_windows want=%0d", NWIN);
    end else begin
      w = got_q[0].win;
      if (w[0 +: BITS] !== BITS'(0) || w[(K*K-1)*BITS +: BITS] !== BITS'(FIRST_IDX)) begin
        failures++; $display("FAIL stream_first_win got=%h want_corners=0,%0d", w, FIRST_IDX);
      end
    end
    checks++;
    if (got_q.size() == 0) begin
      failures++; $display("FAIL stream_last_win got=no_windows want=%0d", NWIN);
    end else begin
      w = got_q[got_q.size()-1].win;
      if (w[(K*K-1)*BITS +: BITS] !== BITS'(NPIX - 1) || got_q[got_q.size()-1].last !== 1'b1) begin
        failures++; $display("FAIL stream_last_win got=%h last=%b want_bottom_right=%0d last=1", w, got_q[got_q.size()-1].last, NPIX - 1);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b1;
    fill_seq(0);
    model_frame(0);
    send_frame(FIRST_IDX, 1'b0, 1'b0);
    out_ready = 1'b0;
    send_pixel(frame_pix[FIRST_IDX], 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = frame_pix[FIRST_IDX+1];
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_window !== exp_q[0].win) begin
        failures++; $display("FAIL stall_hold valid=%b got=%h want=%h", out_valid, out_window, exp_q[0].win);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int k = FIRST_IDX + 1; k < NPIX; k++) send_pixel(frame_pix[k], 1'b0, 1'b0);
    drain();
    checks++;
    if (acc_cyc.size() !== NPIX || drv_timeout !== 1'b0) begin
      failures++; $display("FAIL stall_accepts got=%0d want=%0d timeout=%b", acc_cyc.size(), NPIX, drv_timeout);
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL stall_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int n = 0; n < exp_q.size() && n < got_q.size(); n++) begin
      checks++;
      if (got_q[n].win !== exp_q[n].win || got_q[n].last !== exp_q[n].last) begin
        failures++; $display("FAIL stall_win[%0d] got=%h/%b want=%h/%b", n, got_q[n].win, got_q[n].last, exp_q[n].win, exp_q[n].last);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] w;
    do_reset();
    out_ready = 1'b1;
    fill_seq(0);
    model_frame(0);
    send_frame(NPIX, 1'b1, 1'b1);
    fill_seq(100);
    model_frame(NPIX);
    send_frame(NPIX, 1'b1, 1'b1);
    drain();
    checks++;
    if (got_q.size() !== 2 * NWIN || drv_timeout !== 1'b0) begin
      failures++; $display("FAIL b2b_count got=%0d want=%0d timeout=%b", got_q.size(), 2 * NWIN, drv_timeout);
    end
    for (int n = 0; n < exp_q.size() && n < got_q.size(); n++) begin
      checks++;
      if (got_q[n].win !== exp_q[n].win || got_q[n].last !== exp_q[n].last) begin
        failures++; $display("FAIL b2b_win[%0d] got=%h/%b want=%h/%b", n, got_q[n].win, got_q[n].last, exp_q[n].win, exp_q[n].last);
      end
    end
    checks++;
    if (got_q.size() <= NWIN) begin
      failures++; $display("FAIL b2b_second_first got=no_window want=100..%0d", 100 + FIRST_IDX);
    end else begin
      w = got_q[NWIN].win;
      if (w[0 +: BITS] !== BITS'(100) || w[(K*K-1)*BITS +: BITS] !== BITS'(100 + FIRST_IDX)) begin
        failures++; $display("FAIL b2b_second_first got=%h want_corners=100,%0d", w, 100 + FIRST_IDX);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    fill_seq(0);
    send_frame(FIRST_IDX, 1'b0, 1'b0);
    out_ready = 1'b0;
    send_pixel(frame_pix[FIRST_IDX], 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      failures++; $display("FAIL midrst_pending_drop got=%b/%b want=0/0", out_valid, out_last);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_frame(10, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
    @(posedge clk);
    #1;
    clear_logs();
    model_frame(0);
    send_frame(NPIX, 1'b0, 1'b0);
    drain();
    checks++;
    if (got_q.size() !== NWIN) begin failures++; $display("FAIL midrst_count got=%0d want=%0d", got_q.size(), NWIN); end
    for (int n = 0; n < exp_q.size() && n < got_q.size(); n++) begin
      checks++;
      if (got_q[n].win !== exp_q[n].win || got_q[n].last !== exp_q[n].last) begin
        failures++; $display("FAIL midrst_win[%0d] got=%h/%b want=%h/%b", n, got_q[n].win, got_q[n].last, exp_q[n].win, exp_q[n].last);
      end
    end
  endtask

  task automatic test_negative();
    logic [WW-1:0] w;
    do_reset();
    out_ready = 1'b1;
    fill_rand();
    for (int k = 0; k < NPIX; k += 3) frame_pix[k] = {BITS{1'b1}};
    for (int k = 1; k < NPIX; k += 3) frame_pix[k] = BITS'(-65536);
    model_frame(0);
    send_frame(NPIX, 1'b1, 1'b1);
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL neg_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int n = 0; n < exp_q.size() && n < got_q.size(); n++) begin
      checks++;
      if (got_q[n].win !== exp_q[n].win || got_q[n].last !== exp_q[n].last) begin
        failures++; $display("FAIL neg_win[%0d] got=%h/%b want=%h/%b", n, got_q[n].win, got_q[n].last, exp_q[n].win, exp_q[n].last);
      end
    end
    checks++;
    if (got_q.size() == 0) begin
      failures++; $display("FAIL neg_sign got=no_window want=-1,-65536");
    end else begin
      w = got_q[0].win;
      if ($signed(w[0 +: BITS]) != -1 || $signed(w[BITS +: BITS]) != -65536) begin
        failures++; $display("FAIL neg_sign got=%0d,%0d want=-1,-65536", $signed(w[0 +: BITS]), $signed(w[BITS +: BITS]));
      end
    end
  endtask

  task automatic test_random_frames();
    do_reset();
    out_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      fill_rand();
      model_frame(f * NPIX);
      send_frame(NPIX, 1'b1, 1'b1);
    end
    drain();
    checks++;
    if (got_q.size() !== 3 * NWIN || drv_timeout !== 1'b0) begin
      failures++; $display("FAIL rand_count got=%0d want=%0d timeout=%b", got_q.size(), 3 * NWIN, drv_timeout);
    end
    for (int n = 0; n < exp_q.size() && n < got_q.size(); n++) begin
      checks++;
      if (got_q[n].win !== exp_q[n].win || got_q[n].last !== exp_q[n].last) begin
        failures++; $display("FAIL rand_win[%0d] got=%h/%b want=%h/%b", n, got_q[n].win, got_q[n].last, exp_q[n].win, exp_q[n].last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_negative();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
